// File: rtl/fifo_spi_tx.sv
// SPI mode-0 transmitter that drains a show-ahead FIFO one word at a time, MSB first.
// Define FIFO_SPI_TX_BURST_EN to chain queued words inside one chip-select window.
module fifo_spi_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int CLK_DIV    = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] rdata,
    input  logic                  empty,
    output logic                  rd,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    output logic                  busy
);

    localparam int DIV_W = $clog2(CLK_DIV) + 1;
    localparam int BIT_W = $clog2(DATA_WIDTH) + 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LEAD, SHIFT, TRAIL, GAP} state_t;

    state_t                state, state_n;
    logic [DIV_W-1:0]      div, div_n;
    logic [BIT_W-1:0]      bitcnt, bitcnt_n;
    logic [DATA_WIDTH-1:0] shreg, shreg_n;
    logic                  sclk_q, sclk_n;
    logic                  armed;
    logic                  rd_c;
    logic                  div_last;
    logic                  bit_last;
    logic                  can_pop;

    assign div_last = (div == DIV_LAST);
    assign bit_last = (bitcnt == BIT_LAST);
    // armed holds off the first pop until the second clock edge after reset release
    assign can_pop  = armed & enable & ~empty;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            div    <= '0;
            bitcnt <= '0;
            shreg  <= '0;
            sclk_q <= 1'b0;
            armed  <= 1'b0;
        end else begin
            state  <= state_n;
            div    <= div_n;
            bitcnt <= bitcnt_n;
            shreg  <= shreg_n;
            sclk_q <= sclk_n;
            armed  <= 1'b1;
        end
    end

    always_comb begin
        state_n  = state;
        div_n    = div + DIV_W'(1);
        bitcnt_n = bitcnt;
        shreg_n  = shreg;
        sclk_n   = sclk_q;
        rd_c     = 1'b0;
        case (state)
            IDLE: begin
                div_n    = '0;
                bitcnt_n = '0;
                if (can_pop) begin
                    rd_c    = 1'b1;
                    shreg_n = rdata;
                    state_n = LEAD;
                end
            end
            LEAD: begin
                if (div_last) begin
                    div_n    = '0;
                    bitcnt_n = '0;
                    state_n  = SHIFT;
                end
            end
            SHIFT: begin
                if (div_last) begin
                    div_n  = '0;
                    sclk_n = ~sclk_q;
                    // data only moves on the falling edge, so it is stable across every rise
                    if (sclk_q) begin
                        shreg_n  = shreg << 1;
                        bitcnt_n = bitcnt + BIT_W'(1);
                        if (bit_last) begin
                            bitcnt_n = '0;
`ifdef FIFO_SPI_TX_BURST_EN
                            if (can_pop) begin
                                rd_c    = 1'b1;
                                shreg_n = rdata;
                            end else begin
                                state_n = TRAIL;
                            end
`else
                            state_n = TRAIL;
`endif
                        end
                    end
                end
            end
            TRAIL: begin
                if (div_last) begin
                    div_n   = '0;
                    state_n = GAP;
                end
            end
            GAP: begin
                if (div_last) begin
                    div_n   = '0;
                    state_n = IDLE;
                end
            end
            default: begin
                div_n   = '0;
                state_n = IDLE;
            end
        endcase
    end

    assign rd   = rd_c;
    assign sclk = sclk_q;
    assign cs_n = ~((state == LEAD) || (state == SHIFT) || (state == TRAIL));
    assign mosi = ~cs_n & shreg[DATA_WIDTH-1];
    assign busy = (state != IDLE);

endmodule

// File: tb/tb_fifo_spi_tx.sv
// Scoreboard bench for fifo_spi_tx: a FIFO model queues expected bits on each pop,
// and a monitor compares mosi at every rising sclk and measures chip-select windows.
`timescale 1ns/1ps
module tb_fifo_spi_tx;

    localparam int DW = 8;
    localparam int CD = 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          enable = 1'b0;
    logic [DW-1:0] rdata = '0;
    logic          empty = 1'b1;
    logic          rd, sclk, mosi, cs_n, busy;

    int compared = 0;
    int mismatched = 0;

    logic [DW-1:0] pushQ[$];
    logic [DW-1:0] fifoQ[$];
    logic          expQ[$];

    int rdCount = 0;
    int rdEmpty = 0;
    int riseCount = 0;
    int winCount = 0;
    int lastWin = 0;
    int lastGap = 0;
    int mosiViol = 0;

    fifo_spi_tx #(.DATA_WIDTH(DW), .CLK_DIV(CD)) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .rdata(rdata), .empty(empty),
        .rd(rd), .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic [DW-1:0] word);
        pushQ.push_back(word);
    endtask

    // FIFO model: pops on rd at the edge, queues that word's bits as the expected stream
    initial begin
        logic [DW-1:0] w;
        forever begin
            @(posedge clk);
            if (rd) begin
                if (fifoQ.size() == 0) rdEmpty++;
                else begin
                    w = fifoQ.pop_front();
                    rdCount++;
                    for (int i = DW - 1; i >= 0; i--) expQ.push_back(w[i]);
                end
            end
            while (pushQ.size() > 0) fifoQ.push_back(pushQ.pop_front());
            #1;
            rdata = (fifoQ.size() > 0) ? fifoQ[0] : '0;
            empty = (fifoQ.size() == 0);
        end
    end

    // Monitor: bit compare on each sclk rise, cs_n window and gap measurement
    initial begin
        logic sclkPrev = 1'b0;
        logic csPrev = 1'b1;
        int   lowLen = 0;
        int   highLen = 0;
        logic e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                sclkPrev = 1'b0;
                csPrev = 1'b1;
                lowLen = 0;
                highLen = 0;
            end else begin
                if (cs_n && mosi) mosiViol++;
                if (sclk && !sclkPrev) begin
                    riseCount++;
                    if (expQ.size() == 0) checkOutput("unexpected_sclk_rise", 32'd1, 32'd0);
                    else begin
                        e = expQ.pop_front();
                        checkOutput("mosi_bit", {31'd0, mosi}, {31'd0, e});
                    end
                end
                sclkPrev = sclk;
                if (!cs_n) begin
                    if (csPrev) lastGap = highLen;
                    lowLen++;
                end else begin
                    if (!csPrev) begin
                        lastWin = lowLen;
                        winCount++;
                        lowLen = 0;
                        highLen = 0;
                    end
                    highLen++;
                end
                csPrev = cs_n;
            end
        end
    end

    task automatic waitQuiet(input string name);
        int quiet = 0;
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if (!busy && fifoQ.size() == 0 && pushQ.size() == 0) quiet++;
            else quiet = 0;
            if (quiet >= 3) return;
        end
        checkOutput({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic waitRises(input int target, input string name);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (riseCount >= target) return;
        end
        checkOutput({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic waitBusyFall(input string name);
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (!busy) return;
        end
        checkOutput({name, "_timeout"}, 32'd1, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: got running, expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        int rd0, rise0, win0, viol;

        // Reset state, with a word waiting and enable high
        repeat (2) @(negedge clk);
        enable = 1'b1;
        applyStimulus(8'hA5);
        repeat (3) @(negedge clk);
        checkOutput("reset_rd", {31'd0, rd}, 32'd0);
        checkOutput("reset_cs_n", {31'd0, cs_n}, 32'd1);
        checkOutput("reset_sclk", {31'd0, sclk}, 32'd0);
        checkOutput("reset_mosi", {31'd0, mosi}, 32'd0);
        checkOutput("reset_busy", {31'd0, busy}, 32'd0);
        rst_n = 1'b1;
        #1;
        checkOutput("rd_before_first_edge", {31'd0, rd}, 32'd0);

        // Single word 0xA5
        rd0 = rdCount; rise0 = riseCount; win0 = winCount;
        waitQuiet("word_a5");
        checkOutput("a5_rd_pulses", rdCount - rd0, 32'd1);
        checkOutput("a5_rises", riseCount - rise0, 32'd8);
        checkOutput("a5_windows", winCount - win0, 32'd1);
        checkOutput("a5_cs_low_len", lastWin, 32'd36);

        // Empty FIFO with enable high stays idle
        viol = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rd || !cs_n || sclk || busy) viol++;
        end
        checkOutput("empty_idle_hold", viol, 32'd0);

        // Two queued words 0x3C, 0xFF
        rd0 = rdCount; rise0 = riseCount; win0 = winCount;
        applyStimulus(8'h3C);
        applyStimulus(8'hFF);
        waitQuiet("pair");
        checkOutput("pair_rd_pulses", rdCount - rd0, 32'd2);
        checkOutput("pair_rises", riseCount - rise0, 32'd16);
`ifdef FIFO_SPI_TX_BURST_EN
        checkOutput("pair_windows", winCount - win0, 32'd1);
        checkOutput("pair_cs_low_len", lastWin, 32'd68);
`else
        checkOutput("pair_windows", winCount - win0, 32'd2);
        checkOutput("pair_cs_low_len", lastWin, 32'd36);
        checkOutput("pair_gap_ge_2", {31'd0, lastGap >= 2}, 32'd1);
`endif

        // Reset asserted mid-shift of 0x81; 0x42 must follow intact
        rd0 = rdCount;
        applyStimulus(8'h81);
        applyStimulus(8'h42);
        waitRises(riseCount + 3, "mid_shift");
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("async_cs_n", {31'd0, cs_n}, 32'd1);
        checkOutput("async_sclk", {31'd0, sclk}, 32'd0);
        checkOutput("async_mosi", {31'd0, mosi}, 32'd0);
        checkOutput("async_busy", {31'd0, busy}, 32'd0);
        expQ.delete();
        repeat (2) @(negedge clk);
        checkOutput("reset_hold_rd", {31'd0, rd}, 32'd0);
        rise0 = riseCount; win0 = winCount;
        rst_n = 1'b1;
        waitQuiet("after_reset");
        checkOutput("reset_rd_pulses", rdCount - rd0, 32'd2);
        checkOutput("after_reset_rises", riseCount - rise0, 32'd8);
        checkOutput("after_reset_cs_low_len", lastWin, 32'd36);

        // enable dropped after the third rise, two words queued
        rd0 = rdCount;
        applyStimulus(8'h5A);
        applyStimulus(8'h99);
        waitRises(riseCount + 3, "drop_enable");
        enable = 1'b0;
        waitBusyFall("drop_word_done");
        checkOutput("drop_one_rd", rdCount - rd0, 32'd1);
        checkOutput("drop_cs_low_len", lastWin, 32'd36);
        repeat (20) @(negedge clk);
        checkOutput("drop_still_one_rd", rdCount - rd0, 32'd1);
        checkOutput("drop_idle_busy", {31'd0, busy}, 32'd0);
        enable = 1'b1;
        waitQuiet("resume");
        checkOutput("resume_rd_total", rdCount - rd0, 32'd2);

        checkOutput("mosi_zero_when_cs_high", mosiViol, 32'd0);
        checkOutput("rd_while_empty", rdEmpty, 32'd0);
        checkOutput("expected_bits_left", expQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
